// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with frame-aligned pulse width updates
// Optional feature macro: SERVO_PWM_SLEW_EN (limits the per-frame change of each active pulse width to SLEW_US)
module servo_pwm_multi #(
    parameter int CLK_HZ    = 50000000,
    parameter int NCH       = 4,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int PW_W      = 15,
    parameter int SLEW_US   = 10,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [PW_W-1:0] wr_pw,
    output logic [NCH-1:0]  pwm_out,
    output logic            frame_start,
    output logic            running
);

    // Clocks per microsecond and the counter terminal values derived from it.
    localparam int DIV  = CLK_HZ / 1000000;
    localparam int PS_W = $clog2(DIV);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
    localparam logic [PW_W-1:0] US_LAST = PW_W'(PERIOD_US - 1);
    localparam logic [PW_W-1:0] MIN_V   = PW_W'(MIN_US);
    localparam logic [PW_W-1:0] MAX_V   = PW_W'(MAX_US);
    localparam logic [PW_W-1:0] MID_V   = PW_W'((MIN_US + MAX_US) / 2);
`ifdef SERVO_PWM_SLEW_EN
    localparam logic [PW_W-1:0] SLEW_V  = PW_W'(SLEW_US);
`endif

    // Parameter sanity: a bad configuration stops elaboration instead of producing wrong timing.
    if ((CLK_HZ % 1000000) != 0 || (CLK_HZ / 1000000) < 2) begin : g_chk_clk
        $error("servo_pwm_multi: CLK_HZ must be a whole number of MHz, at least 2");
    end
    if (NCH < 1 || NCH > 16) begin : g_chk_nch
        $error("servo_pwm_multi: NCH must be in 1..16");
    end
    if (MIN_US > MAX_US || MAX_US >= PERIOD_US) begin : g_chk_range
        $error("servo_pwm_multi: need MIN_US <= MAX_US < PERIOD_US");
    end
    if ((64'd1 << PW_W) <= 64'(PERIOD_US)) begin : g_chk_pw_w
        $error("servo_pwm_multi: PW_W too narrow for PERIOD_US");
    end
    if (SLEW_US < 1) begin : g_chk_slew
        $error("servo_pwm_multi: SLEW_US must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [PS_W-1:0] presc_q;
    logic [PS_W-1:0] presc_d;
    logic [PW_W-1:0] us_cnt_q;
    logic [PW_W-1:0] us_cnt_d;

    // pending holds the most recent accepted write; active is what the current frame uses.
    logic [PW_W-1:0] pending_q [NCH];
    logic [PW_W-1:0] pending_d [NCH];
    logic [PW_W-1:0] active_q  [NCH];
    logic [PW_W-1:0] active_d  [NCH];

    logic [NCH-1:0]  pwm_d;
    logic            frame_start_d;
    logic            running_d;

    logic            us_tick;
    logic            frame_end;
    logic            boundary;
    logic            wr_fire;

    // Saturate a requested width into the safe servo range.
    function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] pw);
        if (pw < MIN_V) begin
            clamp_pw = MIN_V;
        end else if (pw > MAX_V) begin
            clamp_pw = MAX_V;
        end else begin
            clamp_pw = pw;
        end
    endfunction

    // Timebase events; the IDLE->RUN step is a boundary too so the first frame starts cleanly.
    assign us_tick   = (state_q != S_IDLE) && (presc_q == PS_LAST);
    assign frame_end = us_tick && (us_cnt_q == US_LAST);
    assign boundary  = frame_end || ((state_q == S_IDLE) && enable);

    // Writes are held off only on the boundary cycle, so a write can never race the active update.
    assign wr_ready  = !rst && !boundary;
    assign wr_fire   = wr_valid && wr_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RUN drops to DRAIN on enable low; DRAIN only stops at a frame end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (enable) begin
                    state_d = S_RUN;
                end else if (frame_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values: counters, width bookkeeping and the pre-registered outputs.
    always_comb begin
        presc_d  = '0;
        us_cnt_d = '0;
        if (state_q != S_IDLE) begin
            presc_d  = us_tick ? '0 : presc_q + 1'b1;
            us_cnt_d = us_cnt_q;
            if (us_tick) begin
                us_cnt_d = (us_cnt_q == US_LAST) ? '0 : us_cnt_q + 1'b1;
            end
        end

        pending_d = pending_q;
        for (int i = 0; i < NCH; i++) begin
            if (wr_fire && (wr_ch == i[CHW-1:0])) begin
                pending_d[i] = clamp_pw(wr_pw);
            end
        end

        active_d = active_q;
        if (boundary) begin
            for (int i = 0; i < NCH; i++) begin
                if (state_q == S_IDLE) begin
                    active_d[i] = pending_q[i];
                end else begin
`ifdef SERVO_PWM_SLEW_EN
                    if (pending_q[i] > active_q[i]) begin
                        active_d[i] = ((pending_q[i] - active_q[i]) > SLEW_V) ?
                                      active_q[i] + SLEW_V : pending_q[i];
                    end else begin
                        active_d[i] = ((active_q[i] - pending_q[i]) > SLEW_V) ?
                                      active_q[i] - SLEW_V : pending_q[i];
                    end
`else
                    active_d[i] = pending_q[i];
`endif
                end
            end
        end

        // Outputs are computed from next-cycle counters so the pulse starts with frame_start.
        running_d     = (state_d != S_IDLE);
        frame_start_d = boundary && (state_d != S_IDLE);
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = running_d && (us_cnt_d < active_d[i]);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            us_cnt_q    <= '0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
            running     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                pending_q[i] <= MID_V;
                active_q[i]  <= MID_V;
            end
        end else begin
            presc_q     <= presc_d;
            us_cnt_q    <= us_cnt_d;
            pwm_out     <= pwm_d;
            frame_start <= frame_start_d;
            running     <= running_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - randomized self-checking bench for servo_pwm_multi against a frame-level model
`timescale 1ns/1ps
module tb_servo_pwm_multi;

    localparam int CLK_HZ    = 3000000;
    localparam int NCH       = 3;
    localparam int PERIOD_US = 100;
    localparam int MIN_US    = 20;
    localparam int MAX_US    = 60;
    localparam int PW_W      = 8;
    localparam int SLEW_US   = 4;
    localparam int CHW       = 2;
    localparam int DIV       = CLK_HZ / 1000000;
    localparam int FRAME     = PERIOD_US * DIV;
    localparam int MID       = (MIN_US + MAX_US) / 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            wr_valid;
    logic            wr_ready;
    logic [CHW-1:0]  wr_ch;
    logic [PW_W-1:0] wr_pw;
    logic [NCH-1:0]  pwm_out;
    logic            frame_start;
    logic            running;

    int checks = 0;
    int errors = 0;

    servo_pwm_multi #(
        .CLK_HZ(CLK_HZ), .NCH(NCH), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .PW_W(PW_W), .SLEW_US(SLEW_US)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_pw(wr_pw), .pwm_out(pwm_out), .frame_start(frame_start),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < MIN_US) return MIN_US;
        if (v > MAX_US) return MAX_US;
        return v;
    endfunction

    // Frame-level model: position in frame (clocks), running/draining flags, widths in us.
    bit m_valid = 1'b0;
    bit m_run   = 1'b0;
    bit m_drain = 1'b0;
    int m_pos   = 0;
    int m_pend [NCH];
    int m_act  [NCH];

    always @(negedge clk) begin
        bit bnd;
        int exp_pwm;
        int ch;
        bnd = m_run ? (m_pos == FRAME - 1) : enable;
        if (m_valid) begin
            exp_pwm = 0;
            for (int i = 0; i < NCH; i++) begin
                if (m_run && (m_pos < m_act[i] * DIV)) exp_pwm |= (1 << i);
            end
            check("pwm_out", int'(pwm_out), exp_pwm);
            check("frame_start", int'(frame_start), (m_run && m_pos == 0) ? 1 : 0);
            check("running", int'(running), int'(m_run));
            check("wr_ready", int'(wr_ready), (!rst && !bnd) ? 1 : 0);
        end
        if (rst) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_drain = 1'b0;
            m_pos   = 0;
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = MID;
                m_act[i]  = MID;
            end
        end else begin
            ch = int'(wr_ch);
            if (wr_valid && !bnd && ch < NCH) m_pend[ch] = clamp(int'(wr_pw));
            if (!m_run) begin
                if (enable) begin
                    m_run   = 1'b1;
                    m_drain = 1'b0;
                    m_pos   = 0;
                    for (int i = 0; i < NCH; i++) m_act[i] = m_pend[i];
                end
            end else if (m_pos == FRAME - 1) begin
                if (m_drain && !enable) begin
                    m_run = 1'b0;
                    m_pos = 0;
                end else begin
                    m_pos = 0;
                    for (int i = 0; i < NCH; i++) begin
`ifdef SERVO_PWM_SLEW_EN
                        if (m_pend[i] > m_act[i] + SLEW_US) m_act[i] = m_act[i] + SLEW_US;
                        else if (m_pend[i] < m_act[i] - SLEW_US) m_act[i] = m_act[i] - SLEW_US;
                        else m_act[i] = m_pend[i];
`else
                        m_act[i] = m_pend[i];
`endif
                    end
                    m_drain = !enable;
                end
            end else begin
                m_pos++;
                m_drain = !enable;
            end
        end
    end

    // Measurements for literal checks: last completed pulse length per channel, frame period.
    int run_len    [NCH];
    int last_width [NCH];
    int fs_count    = 0;
    int last_period = 0;
    int cyc_cnt     = 0;
    int last_fs_cyc = -1;

    always @(negedge clk) begin
        cyc_cnt++;
        for (int i = 0; i < NCH; i++) begin
            if (pwm_out[i]) begin
                run_len[i]++;
            end else if (run_len[i] != 0) begin
                last_width[i] = run_len[i];
                run_len[i] = 0;
            end
        end
        if (frame_start) begin
            if (last_fs_cyc >= 0) last_period = cyc_cnt - last_fs_cyc;
            last_fs_cyc = cyc_cnt;
            fs_count++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the caller 1 ns after the edge that ends the frame_start cycle.
    task automatic wait_fs();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * FRAME + 10 && !seen; k++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        check("wait_frame_start_timeout", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input int ch, input int pw);
        wr_valid = 1'b1;
        wr_ch    = CHW'(ch);
        wr_pw    = PW_W'(pw);
        cyc(1);
        wr_valid = 1'b0;
    endtask

    initial begin
        int fs0;
        int zeros;
        bit acc;
        bit fs_at_acc;
        for (int i = 0; i < NCH; i++) begin
            run_len[i] = 0;
            last_width[i] = 0;
        end
        rst = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_pw = '0;
        cyc(4);
        @(negedge clk);
        check("reset_wr_ready", int'(wr_ready), 0);
        check("reset_running", int'(running), 0);
        cyc(1);

        // Idle with enable low: no frames, ready asserted, outputs low.
        rst = 1'b0;
        fs0 = fs_count;
        cyc(600);
        @(negedge clk);
        check("idle_wr_ready", int'(wr_ready), 1);
        check("idle_pwm", int'(pwm_out), 0);
        check("idle_no_frame_start", fs_count - fs0, 0);
        cyc(1);

        // Default widths after enable.
        enable = 1'b1;
        wait_fs();
        wait_fs();
        check("frame_period", last_period, 300);
        cyc(200);
        check("default_w0", last_width[0], 120);
        check("default_w1", last_width[1], 120);
        check("default_w2", last_width[2], 120);

        // Mid-frame write takes effect only on the following frame.
        wait_fs();
        cyc(149);
        write1(1, 33);
        check("cur_frame_w1", last_width[1], 120);
        wait_fs();
        cyc(200);
        check("next_frame_w1", last_width[1], 99);
        check("next_frame_w0", last_width[0], 120);
        check("next_frame_w2", last_width[2], 120);

        // Clamping and out-of-range channel.
        write1(0, 5);
        write1(2, 200);
        write1(3, 50);
        wait_fs();
        cyc(200);
        check("clamp_low_w0", last_width[0], 60);
        check("ch3_no_effect_w1", last_width[1], 99);
        check("clamp_high_w2", last_width[2], 180);

        // Write held across the boundary cycle.
        wait_fs();
        cyc(298);
        wr_valid = 1'b1; wr_ch = 2'd1; wr_pw = 8'd50;
        zeros = 0; acc = 1'b0; fs_at_acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            if (wr_ready) begin
                acc = 1'b1;
                fs_at_acc = frame_start;
            end else begin
                zeros++;
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        check("hold_ready_low_cycles", zeros, 1);
        check("hold_accept_on_frame_start", int'(fs_at_acc), 1);
        cyc(200);
        check("hold_old_w1", last_width[1], 99);
        wait_fs();
        cyc(200);
        check("hold_new_w1", last_width[1], 150);

        // Drop enable at us 80: frame completes, then stop.
        wait_fs();
        cyc(239);
        enable = 1'b0;
        fs0 = fs_count;
        cyc(50);
        @(negedge clk);
        check("drain_running", int'(running), 1);
        cyc(20);
        @(negedge clk);
        check("stopped_running", int'(running), 0);
        check("stopped_pwm", int'(pwm_out), 0);
        check("stopped_no_frame_start", fs_count - fs0, 0);
        cyc(1);

        // Re-raise enable during drain: no gap in frames.
        enable = 1'b1;
        wait_fs();
        cyc(99);
        enable = 1'b0;
        cyc(100);
        enable = 1'b1;
        wait_fs();
        check("redrain_period", last_period, 300);

        // Reset mid-pulse drops outputs and forgets pending widths.
        cyc(9);
        rst = 1'b1;
        cyc(1);
        @(negedge clk);
        check("midpulse_reset_pwm", int'(pwm_out), 0);
        check("midpulse_reset_running", int'(running), 0);
        cyc(1);
        rst = 1'b0;
        wait_fs();
        cyc(200);
        check("after_reset_w1", last_width[1], 120);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 12000; n++) begin
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_ch    = CHW'($urandom_range(0, 3));
            wr_pw    = PW_W'($urandom_range(0, 120));
            if ($urandom_range(0, 599) == 0) enable = ~enable;
            rst = ($urandom_range(0, 3999) == 0);
            cyc(1);
        end
        rst = 1'b0; wr_valid = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
